a12_scanline_irq: RTL

- Scanline IRQ engine that sits directly upstream of the mapper IRQ output (MMC3/Taito-class mappers 4, 33/48, 118, ...).
- Qualifies rising edges of PPU A12, sampled on M2, into one clean clock pulse per scanline.
- Drives an 8-bit reload/down counter from those pulses and raises a level IRQ pending flag.
- Mappers decode their own register writes into the strobes below; this block owns filter, counter, pending state and savestate access.

---
 rtl/map_irq_pkg.sv | 30 +++
 rtl/a12_scanline_irq_if.sv | 26 ++
 rtl/a12_edge_filter.sv | 31 +++
 rtl/a12_scanline_irq.sv | 103 ++++++++++
 4 files changed

// File: rtl/map_irq_pkg.sv
// Shared definitions for scanline IRQ engines: savestate register map,
// default A12 filter timing and the packed flags byte layout.
package map_irq_pkg;

   // Default A12 filter timing, shared by every mapper that reuses the filter
   localparam int LOW_MIN_DEF  = 3;
   localparam int EDGE_TAP_DEF = 4;
   localparam int HIST_W_DEF   = 11;

   // Savestate register offsets; offset 3 is unmapped
   typedef enum logic [1:0] {
      SST_IRQ_LATCH = 2'd0,
      SST_IRQ_CTR   = 2'd1,
      SST_IRQ_FLAGS = 2'd2,
      SST_IRQ_NONE  = 2'd3
   } sst_sel_t;

   // Flag bits as stored in the savestate flags byte, msb first
   typedef struct packed {
      logic irq_pend;
      logic reload_req;
      logic irq_en;
   } irq_flags_t;

   // Zero-extend the flags into the byte seen on the savestate bus
   function automatic logic [7:0] packFlags(input irq_flags_t f);
      return {5'b00000, f};
   endfunction

endpackage

// File: rtl/a12_scanline_irq_if.sv
// Register-strobe and savestate bus between a mapper's register decode
// (master) and the scanline IRQ engine (slave).
interface a12_scanline_irq_if;
   logic       latch_we;
   logic [7:0] latch_val;
   logic       reload_req_we;
   logic       irq_en_we;
   logic       irq_dis_we;
   logic       sst_act;
   logic       sst_we;
   logic [1:0] sst_addr;
   logic [7:0] sst_dato;
   logic [7:0] sst_di;

   modport master (
      output latch_we, latch_val, reload_req_we, irq_en_we, irq_dis_we,
      output sst_act, sst_we, sst_addr, sst_dato,
      input  sst_di
   );

   modport slave (
      input  latch_we, latch_val, reload_req_we, irq_en_we, irq_dis_we,
      input  sst_act, sst_we, sst_addr, sst_dato,
      output sst_di
   );
endinterface

// File: rtl/a12_edge_filter.sv
// PPU A12 rise qualifier: keeps a history of A12 samples taken on the
// falling edge of M2 and flags a rise only after a run of low samples,
// which rejects the short A12 blips seen during sprite/background fetches.
module a12_edge_filter
   import map_irq_pkg::*;
#(
   parameter int LOW_MIN  = LOW_MIN_DEF,
   parameter int EDGE_TAP = EDGE_TAP_DEF,
   parameter int HIST_W   = HIST_W_DEF
) (
   input  logic m2,
   input  logic map_rst_n,
   input  logic i_freeze,
   input  logic i_a12,
   output logic o_pulse
);

   logic [HIST_W-1:0] r_hist;

   // Shift in one A12 sample per M2 cycle unless held for savestate access
   always_ff @(negedge m2) begin
      if (!map_rst_n) begin
         r_hist <= '0;
      end else if (!i_freeze) begin
         r_hist <= HIST_W'({r_hist, i_a12});
      end
   end

   assign o_pulse = r_hist[EDGE_TAP] & ~(|r_hist[EDGE_TAP+1 +: LOW_MIN]);

endmodule

// File: rtl/a12_scanline_irq.sv
// Scanline IRQ engine for MMC3/Taito-class mappers. Filtered A12 rises
// clock an 8-bit reload/down counter; reaching zero with IRQs enabled
// latches a level IRQ. Mapper register writes arrive as strobes, and the
// whole state is visible and writable through the savestate port.
module a12_scanline_irq
   import map_irq_pkg::*;
#(
   parameter int LOW_MIN  = LOW_MIN_DEF,
   parameter int EDGE_TAP = EDGE_TAP_DEF,
   parameter int HIST_W   = HIST_W_DEF
) (
   input  logic                m2,
   input  logic                map_rst_n,
   input  logic                ppu_a12,
   input  logic                mmc3b_mode,
   a12_scanline_irq_if.slave   regs,
   output logic                irq,
   output logic [7:0]          ctr,
   output logic                a12_clk
);

   logic [7:0] r_latch;
   logic [7:0] r_ctr;
   irq_flags_t r_flags;
   logic       w_pulse;
   logic       w_nextZero;
   logic [7:0] w_ctrNext;

   a12_edge_filter #(
      .LOW_MIN  (LOW_MIN),
      .EDGE_TAP (EDGE_TAP),
      .HIST_W   (HIST_W)
   ) u_filter (
      .m2        (m2),
      .map_rst_n (map_rst_n),
      .i_freeze  (regs.sst_act),
      .i_a12     (ppu_a12),
      .o_pulse   (w_pulse)
   );

   // Decide what a scanline pulse would do: whether it lands on zero and the next count
   always_comb begin
      w_nextZero = ((r_ctr == 8'd1) & ~r_flags.reload_req)
                 | (r_flags.reload_req & (r_latch == 8'd0))
                 | (mmc3b_mode & (r_ctr == 8'd0) & (r_latch == 8'd0));
      w_ctrNext  = ((r_ctr == 8'd0) | r_flags.reload_req) ? r_latch : (r_ctr - 8'd1);
   end

   // Counter and flags: savestate access freezes everything, otherwise the pulse acts first and strobes override it
   always_ff @(negedge m2) begin
      if (!map_rst_n) begin
         r_latch <= 8'd0;
         r_ctr   <= 8'd0;
         r_flags <= '0;
      end else if (regs.sst_act) begin
         if (regs.sst_we) begin
            case (sst_sel_t'(regs.sst_addr))
               SST_IRQ_LATCH: r_latch <= regs.sst_dato;
               SST_IRQ_CTR:   r_ctr   <= regs.sst_dato;
               SST_IRQ_FLAGS: r_flags <= irq_flags_t'(regs.sst_dato[2:0]);
               default:       ;
            endcase
         end
      end else begin
         if (w_pulse) begin
            if (r_flags.irq_en & w_nextZero) begin
               r_flags.irq_pend <= 1'b1;
            end
            r_ctr              <= w_ctrNext;
            r_flags.reload_req <= 1'b0;
         end
         if (regs.latch_we) begin
            r_latch <= regs.latch_val;
         end
         if (regs.reload_req_we) begin
            r_flags.reload_req <= 1'b1;
         end
         if (regs.irq_en_we) begin
            r_flags.irq_en <= 1'b1;
         end
         if (regs.irq_dis_we) begin
            r_flags.irq_en   <= 1'b0;
            r_flags.irq_pend <= 1'b0;
         end
      end
   end

   // Savestate read mux; the unmapped offset reads as all ones
   always_comb begin
      regs.sst_di = 8'hFF;
      case (sst_sel_t'(regs.sst_addr))
         SST_IRQ_LATCH: regs.sst_di = r_latch;
         SST_IRQ_CTR:   regs.sst_di = r_ctr;
         SST_IRQ_FLAGS: regs.sst_di = packFlags(r_flags);
         default:       regs.sst_di = 8'hFF;
      endcase
   end

   assign irq     = r_flags.irq_pend;
   assign ctr     = r_ctr;
   assign a12_clk = w_pulse;

endmodule
